// File: rtl/vram_pkg.sv
// Shared sizes and fill-state encoding for the VRAM arbiter and fill sequencer.
package vram_pkg;

  localparam int unsigned DEPTH  = 600;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return 32'(addr) < DEPTH;
  endfunction

endpackage

// File: rtl/vram_fill_seq.sv
// Whole-screen fill engine: walks every VRAM word once, yielding to video fetches.
module vram_fill_seq
  import vram_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FILL;
          cnt_d   = '0;
          data_d  = data_i;
        end
      end
      FILL: begin
        // A stalled cycle neither writes nor advances, so the last word is never skipped.
        if (!stall_i) begin
          if (cnt_q == LastAddr) state_d = DONE;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign req_o  = (state_q == FILL);
  assign addr_o = cnt_q;
  assign data_o = data_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video > fill > host, one RAM access per cycle.
module vram_arbiter
  import vram_pkg::*;
(
  input  logic              axi_aclk,
  input  logic              axi_areset,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [STRB_W-1:0] host_wstrb,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              ram_en,
  output logic [STRB_W-1:0] ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic              fill_req;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_wdata;

  vram_fill_seq u_fill_seq (
    .clk_i   (axi_aclk),
    .rst_i   (axi_areset),
    .start_i (fill_start),
    .stall_i (vid_req),
    .data_i  (fill_data),
    .req_o   (fill_req),
    .addr_o  (fill_addr),
    .data_o  (fill_wdata),
    .busy_o  (fill_busy),
    .done_o  (fill_done)
  );

  logic              access;
  logic [ADDR_W-1:0] sel_addr;
  logic [STRB_W-1:0] sel_we;
  logic [DATA_W-1:0] sel_wdata;
  logic              hit;

  assign host_gnt = host_req & ~vid_req & ~fill_busy;

  always_comb begin
    access    = 1'b1;
    sel_addr  = host_addr;
    sel_we    = '0;
    sel_wdata = host_wdata;
    if (vid_req) begin
      sel_addr = vid_addr;
    end else if (fill_req) begin
      sel_addr  = fill_addr;
      sel_we    = '1;
      sel_wdata = fill_wdata;
    end else if (host_gnt) begin
      sel_we = host_we ? host_wstrb : '0;
    end else begin
      access = 1'b0;
    end
    // Out-of-range accesses are still granted but never reach the RAM.
    hit       = access & in_range(sel_addr);
    ram_en    = hit;
    ram_we    = hit ? sel_we : '0;
    ram_addr  = sel_addr;
    ram_wdata = sel_wdata;
  end

  logic              host_rvalid_q, host_rvalid_d;
  logic              host_oob_q, host_oob_d;
  logic              vid_rvalid_q, vid_rvalid_d;
  logic              vid_oob_q, vid_oob_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;

  always_comb begin
    host_rvalid_d = host_gnt & ~host_we;
    host_oob_d    = ~in_range(host_addr);
    vid_rvalid_d  = vid_req;
    vid_oob_d     = ~in_range(vid_addr);
    host_rdata_d  = host_rdata_q;
    vid_rdata_d   = vid_rdata_q;
    if (host_rvalid_q) host_rdata_d = host_oob_q ? '0 : ram_rdata;
    if (vid_rvalid_q)  vid_rdata_d  = vid_oob_q ? '0 : ram_rdata;
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      host_rvalid_q <= 1'b0;
      host_oob_q    <= 1'b0;
      vid_rvalid_q  <= 1'b0;
      vid_oob_q     <= 1'b0;
      host_rdata_q  <= '0;
      vid_rdata_q   <= '0;
    end else begin
      host_rvalid_q <= host_rvalid_d;
      host_oob_q    <= host_oob_d;
      vid_rvalid_q  <= vid_rvalid_d;
      vid_oob_q     <= vid_oob_d;
      host_rdata_q  <= host_rdata_d;
      vid_rdata_q   <= vid_rdata_d;
    end
  end

  // Read data is live in the rvalid cycle and held in a register afterwards.
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_d;
  assign vid_rvalid  = vid_rvalid_q;
  assign vid_rdata   = vid_rdata_d;

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port VRAM arbiter and fill sequencer for the HDMI text controller. It shares one 600-word × 32-bit VRAM port among three requesters:
- the character-fetch side of the text renderer (video);
- the AXI4-Lite slave register logic (host);
- an internal fill engine that clears or fills the whole screen in hardware.

It sits between the AXI slave and the VRAM block RAM, replacing direct host access to the RAM.

## Interface
- DEPTH, 600, number of VRAM words
- ADDR_W, 10, word-address width
- DATA_W, 32, word width

- axi_aclk  in  1  sole clock (AXI and pixel-fetch domain)
- axi_areset  in  1  asynchronous, active-high reset
- host_req  in  1  host access request, held until granted
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host word address
- host_wdata  in  DATA_W  host write data
- host_wstrb  in  DATA_W/8  host byte enables
- host_gnt  out  1  host request accepted this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- vid_req  in  1  video fetch request, never stalled
- vid_addr  in  ADDR_W  video word address
- vid_rvalid  out  1  video read data valid
- vid_rdata  out  DATA_W  video read data
- fill_start  in  1  one-cycle pulse that starts a fill
- fill_data  in  DATA_W  word written to every location
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle pulse when the fill completes
- ram_en, ram_we[DATA_W/8], ram_addr[ADDR_W], ram_wdata[DATA_W]  out  RAM port
- ram_rdata  in  DATA_W  RAM read data, 1-cycle latency

## Operation
- **Priority each cycle:** video > fill > host. At most one RAM access per cycle.
- **Video**
  - vid_req always wins the port. RAM is read at vid_addr.
  - vid_rvalid is asserted exactly 1 cycle later, with vid_rdata = ram_rdata.
- **Host**
  - host_gnt = host_req & ~vid_req & ~fill_busy. host_gnt is combinational.
  - A granted write drives ram_we = host_wstrb. Only the enabled bytes change.
  - A granted read produces host_rvalid 1 cycle later.
  - host_rdata holds its last value until the next host read.
- **Fill FSM (states IDLE, FILL, DONE)**
  - IDLE → FILL on fill_start. fill_data is latched and the address counter is cleared to 0.
  - In FILL, each cycle without vid_req writes the latched word with all strobes to the counter address, then increments the counter.
  - FILL → DONE after address DEPTH−1 is written.
  - DONE → IDLE unconditionally, asserting fill_done for that one cycle.
  - fill_busy = (state != IDLE).
  - fill_start while busy is ignored.
  - A host request pending during a fill waits; it is neither dropped nor reordered.
- **Out-of-range addresses (≥ DEPTH)**
  - Granted normally, but the RAM is not enabled.
  - Writes are discarded.
  - Reads return 0 with normal rvalid timing.
- **Simultaneous events**
  - fill_start together with a granted host access in the same cycle: the host access completes and the fill starts next cycle.
  - vid_req together with the last fill word: the fill word is deferred, and DONE follows the actual final write.

## Timing
- **Reset:** all outputs are 0, FSM in IDLE, counter 0, host_rdata/vid_rdata 0. Reset mid-fill aborts the fill with no fill_done pulse; the RAM contents are left partially filled.
- **Read latency:** 1 cycle, address cycle to rvalid, for both host and video.
- **Write:** takes effect at the clock edge of the grant cycle. A read of the same address in the next cycle returns the new data.
- **Fill duration:** DEPTH + V + 1 cycles from fill_start to fill_done, where V is the number of vid_req cycles seen during FILL. With V = 0 this is 601 cycles.
- **Host throughput:** 1 access per cycle with no video or fill activity. The renderer guarantees vid_req at most 1 in 8 cycles.

## Structure
- **vram_pkg:** DEPTH, ADDR_W, DATA_W, and the fill-state typedef fill_state_t {IDLE, FILL, DONE}.
- **Sub-module vram_fill_seq:** contains the FSM, the address counter and the latched data. It outputs a request, address and data to the arbiter mux and receives a stall input driven by vid_req.
- **vram_arbiter (top):** priority mux, grant logic, range check, and the 1-cycle-delayed rvalid/source tags.

## Test plan
- **Host write/read:** host write addr 5, data 0xDEADBEEF, wstrb 0xF, then a read of addr 5 → host_gnt in both cycles; host_rvalid 1 cycle after the read with host_rdata = 0xDEADBEEF.
- **Byte strobe:** addr 7 preloaded with 0x11223344; write 0xAABBCCDD with wstrb 0x5; read back → 0x11BB33DD.
- **Video priority:** vid_req and host_req in the same cycle at addrs 3 and 9 → host_gnt = 0; video data arrives next cycle; host granted the following cycle and served with correct data.
- **Fill:** fill_start with fill_data 0x00200020, no video → fill_busy for 601 cycles; fill_done pulses once; reads of addrs 0, 299 and 599 return 0x00200020. Repeat with vid_req every 8th cycle → fill_done delayed by the vid count; all words still correct.
- **Boundaries:** host read of addr 600 → rdata 0, RAM not enabled. Host write to addr 1023 → no RAM write. fill_start while busy → ignored, with a single fill_done.
- **Reset mid-fill:** assert axi_areset at counter = 300 → fill_busy and all outputs go to 0 immediately; no fill_done; addrs 0–299 filled, addr 300 unchanged.
